// File: rtl/acc_bias_gen.sv
// Three-lane partial-product accumulator with per-frame bias and saturation to
// the AB_BW signed range; one shared IDLE/ACC/OUT controller with valid/ready on both sides.
module acc_bias_gen #(
  parameter int P_BW      = 16,
  parameter int B_BW      = 16,
  parameter int AB_BW     = 21,
  parameter int MAX_TERMS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_last,
  input  logic signed [P_BW-1:0]  i_psum0,
  input  logic signed [P_BW-1:0]  i_psum1,
  input  logic signed [P_BW-1:0]  i_psum2,
  input  logic signed [B_BW-1:0]  i_bias0,
  input  logic signed [B_BW-1:0]  i_bias1,
  input  logic signed [B_BW-1:0]  i_bias2,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [AB_BW-1:0] o_acc_bias0,
  output logic signed [AB_BW-1:0] o_acc_bias1,
  output logic signed [AB_BW-1:0] o_acc_bias2,
  output logic [2:0]              o_sat
);

  localparam int ACC_W = AB_BW + 1;
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  function automatic logic signed [ACC_W-1:0] f_sext_p(input logic [P_BW-1:0] v);
    return {{(ACC_W-P_BW){v[P_BW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] f_sext_b(input logic [B_BW-1:0] v);
    return {{(ACC_W-B_BW){v[B_BW-1]}}, v};
  endfunction

  // Returns {clipped, value}; the value fits when the two top accumulator bits agree.
  function automatic logic [AB_BW:0] f_sat(input logic [ACC_W-1:0] a);
    logic [AB_BW:0] res;
    if (a[ACC_W-1] != a[ACC_W-2]) begin
      res[AB_BW] = 1'b1;
      if (a[ACC_W-1]) begin
        res[AB_BW-1:0] = {1'b1, {(AB_BW-1){1'b0}}};
      end else begin
        res[AB_BW-1:0] = {1'b0, {(AB_BW-1){1'b1}}};
      end
    end else begin
      res[AB_BW]     = 1'b0;
      res[AB_BW-1:0] = a[AB_BW-1:0];
    end
    return res;
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic signed [ACC_W-1:0]  r_acc [3];
  logic signed [ACC_W-1:0]  w_acc_nxt [3];
  logic [AB_BW:0]           w_sat_res [3];
  logic [AB_BW-1:0]         r_res [3];
  logic [2:0]               r_sat;
  logic                     r_ready;
  logic                     r_valid;
  logic                     w_ready_nxt;
  logic                     w_valid_nxt;
  logic                     w_accept;
  logic                     w_last;
  logic [P_BW-1:0]          w_psum [3];
  logic [B_BW-1:0]          w_bias [3];

  assign w_psum[0] = i_psum0;
  assign w_psum[1] = i_psum1;
  assign w_psum[2] = i_psum2;
  assign w_bias[0] = i_bias0;
  assign w_bias[1] = i_bias1;
  assign w_bias[2] = i_bias2;

  assign w_accept = i_valid && r_ready;

  // Beat bookkeeping: the term count either restarts or advances, and hitting MAX_TERMS forces last.
  always_comb begin
    w_cnt_nxt = {CNT_W{1'b0}};
    w_last    = 1'b0;
    if (r_state == S_IDLE) begin
      w_cnt_nxt = CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    w_last = i_last || (w_cnt_nxt == CNT_W'(MAX_TERMS));
  end

  // Lane datapath: the first beat of a frame folds in the bias, later beats add psum only.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      w_acc_nxt[n] = {ACC_W{1'b0}};
      if (r_state == S_IDLE) begin
        w_acc_nxt[n] = f_sext_b(w_bias[n]) + f_sext_p(w_psum[n]);
      end else begin
        w_acc_nxt[n] = r_acc[n] + f_sext_p(w_psum[n]);
      end
      w_sat_res[n] = f_sat(w_acc_nxt[n]);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACC: begin
        if (w_accept) begin
          if (w_last) begin
            w_state_nxt = S_OUT;
          end else begin
            w_state_nxt = S_ACC;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they can be registered alongside it.
  always_comb begin
    w_ready_nxt = 1'b1;
    w_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE, S_ACC: begin
        w_ready_nxt = 1'b1;
        w_valid_nxt = 1'b0;
      end
      S_OUT: begin
        w_ready_nxt = 1'b0;
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_ready_nxt = 1'b1;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Accumulators, term count and result registers; results only load on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_sat <= 3'b000;
      for (int n = 0; n < 3; n++) begin
        r_acc[n] <= {ACC_W{1'b0}};
        r_res[n] <= {AB_BW{1'b0}};
      end
    end else if (w_accept) begin
      r_cnt <= w_cnt_nxt;
      for (int n = 0; n < 3; n++) begin
        r_acc[n] <= w_acc_nxt[n];
      end
      if (w_last) begin
        for (int n = 0; n < 3; n++) begin
          r_res[n] <= w_sat_res[n][AB_BW-1:0];
          r_sat[n] <= w_sat_res[n][AB_BW];
        end
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_acc_bias0 = r_res[0];
  assign o_acc_bias1 = r_res[1];
  assign o_acc_bias2 = r_res[2];
  assign o_sat       = r_sat;

endmodule

// File: doc/acc_bias_gen.md
ACC_BIAS_GEN -- requirements
Module: acc_bias_gen

Interface
REQ-001 SHALL have parameter P_BW, default 16, signed partial-product width per lane.
REQ-002 SHALL have parameter B_BW, default 16, signed bias width per lane.
REQ-003 SHALL have parameter AB_BW, default 21, signed output width per lane, matching the bounded-ReLU input.
REQ-004 SHALL have parameter MAX_TERMS, default 32, maximum partial products per accumulation.
REQ-005 SHALL have ports, as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- i_last  in  1  final partial product of the current accumulation.
- i_psum0, i_psum1, i_psum2  in  P_BW each  signed partial products, lanes 0..2.
- i_bias0, i_bias1, i_bias2  in  B_BW each  signed biases, lanes 0..2.
- o_valid  out  1  result valid; also usable as bound_en for the ReLU stage.
- i_ready  in  1  downstream accepts the result when o_valid && i_ready.
- o_acc_bias0, o_acc_bias1, o_acc_bias2  out  AB_BW each  signed saturated results.
- o_sat  out  3  per-lane flag: result was clipped.

Function
REQ-006 SHALL implement an FSM with states IDLE, ACC and OUT.
REQ-007 IDLE: o_ready=1 and o_valid=0. The first accepted beat loads acc_n = sext(i_bias_n) + sext(i_psum_n), latches the bias for the frame, and sets term count = 1. The next state is OUT if the beat is last, else ACC.
REQ-008 ACC: o_ready=1. Each accepted beat performs acc_n += sext(i_psum_n) and count += 1. i_bias is ignored in ACC.
REQ-009 A beat is last when i_last=1 or when count reaches MAX_TERMS on that beat, whichever occurs first. A forced last SHALL behave identically to i_last.
REQ-010 Accepting the last beat SHALL transition to OUT. The results are registered, so o_valid rises on the cycle after the last beat is accepted: latency 1 cycle.
REQ-011 Cycles in IDLE or ACC with i_valid=0 SHALL leave acc, count and state unchanged.
REQ-012 The internal accumulator SHALL be AB_BW+1 bits signed. With the default parameters the worst case is 33 x 32768, so it never wraps.
REQ-013 Each output SHALL be saturated to the AB_BW signed range: maximum 2^(AB_BW-1)-1 = 1048575, minimum -2^(AB_BW-1) = -1048576. o_sat[n] SHALL be 1 when lane n was clipped.
REQ-014 OUT: o_valid=1 and o_ready=0. o_acc_bias*, o_sat SHALL stay stable until i_ready=1.
REQ-015 In OUT with i_ready=1: the next state is IDLE and o_valid falls on the next cycle. No upstream beat is accepted in that same cycle, so there is a 1-cycle bubble minimum between frames.
REQ-016 i_last asserted while i_valid=0 SHALL have no effect.
REQ-017 Lanes SHALL share one FSM and one count; lanes are never independent.

Reset
REQ-018 rst=1 at a rising clk edge SHALL force state IDLE, acc=0, count=0, o_valid=0, o_acc_bias*=0 and o_sat=0. o_ready SHALL be 1 from the first cycle after reset.
REQ-019 rst during ACC or OUT SHALL discard the partial or pending result without asserting o_valid. rst has priority over all handshakes in the same cycle.

Verification
REQ-020 Single-beat frame: bias=(10,-200,5), psum=(22,10,115) with i_last=1, i_ready=1 -> the next cycle has o_valid=1 and outputs (32,-190,120), o_sat=000.
REQ-021 Three-beat frame with gaps: bias=(0,0,0); psums (5,-11,10), then an idle cycle, then (5,-11,30), then (10,-11,30) with last -> outputs (20,-33,70), one o_valid per frame.
REQ-022 Backpressure: hold i_ready=0 for 4 cycles after the result -> o_valid and outputs are stable and o_ready=0. i_valid beats offered during the hold are not accepted. Release -> IDLE.
REQ-023 Saturation and forced last: 32 beats of psum=32767 plus bias=32767, i_last never set -> the 32nd beat ends the frame, output 1048575, o_sat=111. The same with -32768 -> -1048576.
REQ-024 Reset mid-frame: rst=1 after 2 beats -> no o_valid. A new single-beat frame with bias=0 and psum=(-1,0,30) -> outputs (-1,0,30).
